clock_set_ctrl: RTL and testbench

- Controller for the hh:mm:ss time-of-day counter.
- Generates the counter's 1 Hz `enable` tick in run mode.
- Sequences the counter's load1/load2/load3 ports from a three-button user interface (mode / inc / dec) so the user can set the hour, minute and second.
- Sits between the debounced, synchronized button inputs and the counter. It reads back the counter's sec/min/hour outputs.

---
 rtl/clock_set_ctrl_pkg.sv | 35 +++
 rtl/clock_set_ctrl_edge.sv | 22 ++
 rtl/clock_set_ctrl.sv | 140 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings and field limits for the time-of-day set controller.
// Mode values double as the FSM state encoding driven onto the mode output.
package clock_set_ctrl_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_SEC  = 2'd3;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        StRun     = MODE_RUN,
        StSetHour = MODE_SET_HOUR,
        StSetMin  = MODE_SET_MIN,
        StSetSec  = MODE_SET_SEC
    } state_e;

    // Which non-seconds field needs its load strobe in the cycle after an edit.
    typedef enum logic [1:0] {
        PendNone,
        PendMin,
        PendHour
    } pend_e;

    function automatic logic [5:0] step_field(input logic [5:0] val, input logic [5:0] max,
                                              input logic up);
        if (up) begin
            return (val == max) ? 6'd0 : val + 6'd1;
        end
        return (val == 6'd0) ? max : val - 6'd1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_edge.sv
// Single-bit rising-edge detector. The previous-value register resets to 1 so a
// level already high when reset releases never produces a pulse.
module edge_pulse (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse = level & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set controller for the hh:mm:ss counter: 1 Hz tick generation in run mode,
// and a three-button editor that keeps the counter frozen via load strobes while setting.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    output logic       enable,
    output logic       load1,
    output logic       load2,
    output logic       load3,
    output logic [5:0] data1,
    output logic [5:0] data2,
    output logic [5:0] data3,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    state_e              state_q, state_d;
    pend_e               pend_q, pend_d;
    logic [TickW-1:0]    presc_q, presc_d;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;
    logic [5:0]          sh_sec_q, sh_sec_d;
    logic [5:0]          sh_min_q, sh_min_d;
    logic [4:0]          sh_hour_q, sh_hour_d;

    logic mode_p, inc_p, dec_p;
    logic do_inc, do_dec;
    logic in_set;

    edge_pulse u_mode_edge (.clock(clock), .reset(reset), .level(btn_mode), .pulse(mode_p));
    edge_pulse u_inc_edge  (.clock(clock), .reset(reset), .level(btn_inc),  .pulse(inc_p));
    edge_pulse u_dec_edge  (.clock(clock), .reset(reset), .level(btn_dec),  .pulse(dec_p));

    // Mode wins over inc/dec; simultaneous inc+dec cancels out.
    assign do_inc = inc_p & ~dec_p & ~mode_p;
    assign do_dec = dec_p & ~inc_p & ~mode_p;
    assign in_set = (state_q != StRun);

    always_comb begin
        state_d     = state_q;
        pend_d      = PendNone;
        presc_d     = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        sh_sec_d    = sh_sec_q;
        sh_min_d    = sh_min_q;
        sh_hour_d   = sh_hour_q;

        if (state_q == StRun) begin
            presc_d = (presc_q == TickLast) ? '0 : presc_q + TickW'(1);
            if (mode_p) begin
                state_d   = StSetHour;
                sh_sec_d  = cur_sec;
                sh_min_d  = cur_min;
                sh_hour_d = cur_hour;
            end
        end else begin
            if (blink_cnt_q == BlinkLast) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
                blink_d     = blink_q;
            end

            if (mode_p) begin
                blink_cnt_d = '0;
                blink_d     = 1'b0;
                unique case (state_q)
                    StSetHour: state_d = StSetMin;
                    StSetMin:  state_d = StSetSec;
                    default:   state_d = StRun;
                endcase
            end else if (do_inc || do_dec) begin
                unique case (state_q)
                    StSetHour: begin
                        sh_hour_d = 5'(step_field({1'b0, sh_hour_q}, {1'b0, HOUR_MAX}, do_inc));
                        pend_d    = PendHour;
                    end
                    StSetMin: begin
                        sh_min_d = step_field(sh_min_q, MINSEC_MAX, do_inc);
                        pend_d   = PendMin;
                    end
                    default: begin
                        sh_sec_d = step_field(sh_sec_q, MINSEC_MAX, do_inc);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StRun;
            pend_q      <= PendNone;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            sh_sec_q    <= '0;
            sh_min_q    <= '0;
            sh_hour_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            sh_sec_q    <= sh_sec_d;
            sh_min_q    <= sh_min_d;
            sh_hour_q   <= sh_hour_d;
        end
    end

    // Exactly one strobe per set cycle; seconds reload is the default that freezes the counter.
    assign enable = ~in_set && (presc_q == TickLast);
    assign load1  = in_set && (pend_q == PendNone);
    assign load2  = in_set && (pend_q == PendMin);
    assign load3  = in_set && (pend_q == PendHour);
    assign data1  = sh_sec_q;
    assign data2  = sh_min_q;
    assign data3  = {1'b0, sh_hour_q};
    assign mode   = state_q;
    assign blink  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl wired to a behavioural hh:mm:ss counter; per-cycle
// expectations are queued when stimulus is driven and compared on the falling edge.
module tb_clock_set_ctrl;

    localparam int BLINK = 3;
    localparam int L0 = 0, L3 = 1, L2 = 2, L1 = 4;  // {load1,load2,load3}

    logic       clock = 1'b0;
    logic       reset, btn_mode, btn_inc, btn_dec;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hour;
    logic       enable, load1, load2, load3, blink;
    logic [5:0] data1, data2, data3;
    logic [1:0] mode;

    logic       preset;
    logic [5:0] pre_sec, pre_min;
    logic [4:0] pre_hour;

    clock_set_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .enable(enable), .load1(load1), .load2(load2), .load3(load3), .data1(data1),
        .data2(data2), .data3(data3), .mode(mode), .blink(blink)
    );

    always #5 clock = ~clock;

    // Time counter: load1 > load2 > load3 > count; seconds roll at 59 even without enable.
    always @(posedge clock) begin
        if (reset) begin
            cur_sec <= '0; cur_min <= '0; cur_hour <= '0;
        end else if (preset) begin
            cur_sec <= pre_sec; cur_min <= pre_min; cur_hour <= pre_hour;
        end else if (load1) begin
            cur_sec <= data1;
        end else if (load2) begin
            cur_min <= data2;
        end else if (load3) begin
            cur_hour <= data3[4:0];
        end else if (enable || cur_sec == 6'd59) begin
            if (cur_sec == 6'd59) begin
                cur_sec <= '0;
                if (cur_min == 6'd59) begin
                    cur_min  <= '0;
                    cur_hour <= (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
                end else begin
                    cur_min <= cur_min + 6'd1;
                end
            end else begin
                cur_sec <= cur_sec + 6'd1;
            end
        end
    end

    typedef struct {
        string      name;
        bit         rst, pre, bm, bi, bd;
        logic [1:0] mode;
        bit         en;
        bit [2:0]   ld;
        logic [5:0] data;
        bit         blink;
    } vec_t;

    vec_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   age = 0;
    int   prev_mode = 0;

    function automatic vec_t mk(string name, int rst, int pre, int bm, int bi, int bd,
                                int md, int en, int ld, int data);
        vec_t v;
        v.name = name; v.rst = (rst != 0); v.pre = (pre != 0);
        v.bm = (bm != 0); v.bi = (bi != 0); v.bd = (bd != 0);
        v.mode = 2'(md); v.en = (en != 0); v.ld = 3'(ld); v.data = 6'(data);
        v.blink = 1'b0;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Blink expectation: 0 in RUN, else toggles every BLINK cycles since the last mode change.
    task automatic apply(vec_t v);
        reset = v.rst; preset = v.pre;
        btn_mode = v.bm; btn_inc = v.bi; btn_dec = v.bd;
        if (int'(v.mode) != prev_mode) age = 0;
        else age++;
        prev_mode = int'(v.mode);
        v.blink = (v.mode != 2'd0) && (((age / BLINK) % 2) == 1);
        sb.push_back(v);
        @(posedge clock);
        #1;
    endtask

    task automatic hold(string nm, int n, int md, int d);
        repeat (n) apply(mk(nm, 0, 0, 0, 0, 0, md, 0, L1, d));
    endtask

    // Press in one cycle, release in the next; the release cycle shows the edit's strobe.
    task automatic edit(string nm, int inc, int md, int sec_before, int ld_after, int d_after);
        apply(mk(nm, 0, 0, 0, inc, (inc == 0) ? 1 : 0, md, 0, L1, sec_before));
        apply(mk(nm, 0, 0, 0, 0, 0, md, 0, ld_after, d_after));
    endtask

    vec_t cv;
    logic [5:0] dact;

    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                cv = sb.pop_front();
                dact = cv.ld[2] ? data1 : cv.ld[1] ? data2 : cv.ld[0] ? data3 : 6'd0;
                check(cv.name, 32'({mode, enable, load1, load2, load3, blink, dact}),
                      32'({cv.mode, cv.en, cv.ld, cv.blink, cv.data}));
            end
        end
    end

    initial begin
        vec_t run_tbl[$];
        vec_t rst_tbl[$];
        int   h;
        int   m;

        for (int k = 1; k <= 12; k++) run_tbl.push_back(mk("run_tick", 0, 0, 0, 0, 0, 0, (k % 4) == 0 ? 1 : 0, L0, 0));
        rst_tbl.push_back(mk("rst_mid_min", 1, 0, 1, 0, 0, 2, 0, L1, 7));
        rst_tbl.push_back(mk("rst_applied", 1, 0, 1, 0, 0, 0, 0, L0, 0));
        rst_tbl.push_back(mk("rst_mode_held", 0, 0, 1, 0, 0, 0, 0, L0, 0));
        rst_tbl.push_back(mk("rst_mode_held", 0, 0, 1, 0, 0, 0, 0, L0, 0));
        rst_tbl.push_back(mk("rst_release", 0, 0, 0, 0, 0, 0, 0, L0, 0));
        rst_tbl.push_back(mk("rst_tick", 0, 0, 0, 0, 0, 0, 1, L0, 0));
        rst_tbl.push_back(mk("rst_after", 0, 0, 0, 0, 0, 0, 0, L0, 0));

        reset = 1'b1; preset = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        pre_sec = '0; pre_min = '0; pre_hour = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ctrl", 32'({mode, enable, load1, load2, load3, blink}), 32'd0);
        check("reset_data", 32'({data1, data2, data3}), 32'd0);

        // Run after reset: ticks at cycles 4, 8, 12.
        foreach (run_tbl[i]) apply(run_tbl[i]);
        check("run_sec", 32'(cur_sec), 32'd3);
        check("run_min_hour", 32'({cur_hour, cur_min}), 32'd0);

        // Enter SET_HOUR at 10:20:30; counter frozen by load1.
        pre_hour = 5'd10; pre_min = 6'd20; pre_sec = 6'd30;
        apply(mk("preset", 0, 1, 0, 0, 0, 0, 0, L0, 0));
        apply(mk("run_to_hour", 0, 0, 1, 0, 0, 0, 0, L0, 0));
        hold("hour_freeze", 100, 1, 30);
        check("freeze_sec", 32'(cur_sec), 32'd30);
        check("freeze_min_hour", 32'({cur_hour, cur_min}), 32'({5'd10, 6'd20}));

        // Hour dec 10 -> 0 -> 23, then inc wraps to 0 and dec back to 23.
        h = 10;
        for (int i = 0; i < 11; i++) begin
            h = (h == 0) ? 23 : h - 1;
            edit("hour_dec", 0, 1, 30, L3, h);
        end
        check("hour_23", 32'(cur_hour), 32'd23);
        hold("hour_l1", 1, 1, 30);
        edit("hour_inc_wrap", 1, 1, 30, L3, 0);
        hold("hour_l1_back", 1, 1, 30);
        check("hour_0", 32'(cur_hour), 32'd0);
        edit("hour_dec_wrap", 0, 1, 30, L3, 23);
        hold("hour_l1_back", 1, 1, 30);

        // SET_MIN: dec 20 -> 0 -> 59.
        apply(mk("hour_to_min", 0, 0, 1, 0, 0, 1, 0, L1, 30));
        hold("min_enter", 1, 2, 30);
        m = 20;
        for (int i = 0; i < 21; i++) begin
            m = (m == 0) ? 59 : m - 1;
            edit("min_dec", 0, 2, 30, L2, m);
        end
        check("min_59", 32'(cur_min), 32'd59);

        // SET_SEC: inc 30 -> 59, then hold with no rollover.
        apply(mk("min_to_sec", 0, 0, 1, 0, 0, 2, 0, L1, 30));
        hold("sec_enter", 1, 3, 30);
        for (int s = 31; s <= 59; s++) edit("sec_inc", 1, 3, s - 1, L1, s);
        hold("sec_hold", 20, 3, 59);
        check("sec_hold_sec", 32'(cur_sec), 32'd59);
        check("sec_hold_min_hour", 32'({cur_hour, cur_min}), 32'({5'd23, 6'd59}));

        // Back to RUN: prescaler restarts, counter rolls 23:59:59 over.
        apply(mk("sec_to_run", 0, 0, 1, 0, 0, 3, 0, L1, 59));
        for (int k = 1; k <= 8; k++) apply(mk("run_restart", 0, 0, 0, 0, 0, 0, (k % 4) == 0 ? 1 : 0, L0, 0));
        check("rollover_sec", 32'(cur_sec), 32'd2);
        check("rollover_min_hour", 32'({cur_hour, cur_min}), 32'd0);

        // Simultaneous presses: mode+inc only advances; inc+dec does nothing.
        pre_hour = 5'd5; pre_min = 6'd6; pre_sec = 6'd7;
        apply(mk("preset2", 0, 1, 0, 0, 0, 0, 0, L0, 0));
        apply(mk("mode_inc_run", 0, 0, 1, 1, 0, 0, 0, L0, 0));
        hold("mode_inc_hour", 2, 1, 7);
        check("mode_inc_hour_val", 32'(cur_hour), 32'd5);
        apply(mk("mode_inc_set", 0, 0, 1, 1, 0, 1, 0, L1, 7));
        hold("mode_inc_min", 2, 2, 7);
        apply(mk("inc_dec_min", 0, 0, 0, 1, 1, 2, 0, L1, 7));
        hold("inc_dec_after", 2, 2, 7);
        check("inc_dec_min_val", 32'(cur_min), 32'd6);
        edit("min_inc", 1, 2, 7, L2, 7);
        hold("min_inc_after", 1, 2, 7);
        check("min_inc_val", 32'(cur_min), 32'd7);

        // Reset mid-SET_MIN with mode held through it.
        foreach (rst_tbl[i]) apply(rst_tbl[i]);
        check("post_reset_data", 32'({data1, data2, data3}), 32'd0);
        check("post_reset_mode", 32'(mode), 32'd0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
